uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter (start, 8 data LSB first, stop).
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        tx_line,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    state_t        state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          load;
`ifdef UART_TX_PARITY_EN
    logic          parity, parity_n;
`endif

    assign in_ready = (fifo_count != FULL);
    assign push     = in_valid & in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = (state != IDLE) || (fifo_count != '0);

    // Storage has no reset: pop is gated by fifo_count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_line  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx_line  <= tx_n;
`ifdef UART_TX_PARITY_EN
            parity   <= parity_n;
`endif
        end
    end

    // tx_line is registered from the next-state value so the line changes on the transition edge.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        tx_n       = tx_line;
        load       = 1'b0;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n   = parity;
`endif
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (fifo_count != '0) load = 1'b1;
            end
            START: begin
                if (baud_cnt == '0) begin
                    state_n    = DATA;
                    baud_cnt_n = RELOAD;
                    bit_idx_n  = '0;
                    tx_n       = shift[0];
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_cnt_n = RELOAD;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = parity;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_cnt == '0) begin
                    state_n    = STOP;
                    baud_cnt_n = RELOAD;
                    tx_n       = 1'b1;
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == '0) begin
                    if (fifo_count != '0) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        if (load) begin
            pop        = 1'b1;
            shift_n    = head;
            state_n    = START;
            baud_cnt_n = RELOAD;
            tx_n       = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_n   = ^head;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frame table, corner-case sequences
// and randomized traffic checked every cycle against a frame-position reference model.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 4;
    localparam int CPB      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       tx_line;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .tx_line   (tx_line),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the clock position inside the current frame.
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_tx = 1'b1;
    int         m_pre;

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_tx     = 1'b1;
        end else begin
            m_pre = mq.size();
            if (m_active) begin
                m_pos++;
                if (m_pos == NB * CPB) m_active = 1'b0;
            end
            if (!m_active && m_pre > 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
            if (in_valid && (m_pre != DEPTH)) mq.push_back(in_data);
            m_tx = m_active ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
        end
    end

    always @(negedge clk) begin
        check("model_tx_line", tx_line, m_tx);
        check("model_busy", busy, m_active || (mq.size() != 0));
        check("model_fifo_count", fifo_count, mq.size());
        check("model_in_ready", in_ready, mq.size() != DEPTH);
    end

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [NB-1:0] exp);
        wait_idle(2000);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("pre_start_tx", tx_line, 1);
        @(posedge clk);
        #1 check("start_edge_tx", tx_line, 0);
        for (int b = 0; b < NB; b++) begin
            repeat ((b == 0) ? 5 : 10) @(posedge clk);
            #1 check($sformatf("frame_%02h_bit%0d", d, b), tx_line, exp[b]);
        end
        repeat (4) @(posedge clk);
        #1 check("busy_last_clk", busy, 1);
        @(posedge clk);
        #1 check("busy_done", busy, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] exp_frame;
        int n;
        int t;
        logic rdy;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'h80, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_line", tx_line, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
`ifdef UART_TX_PARITY_EN
            exp_frame = {1'b1, vecs[i].par, vecs[i].data, 1'b0};
`else
            exp_frame = {1'b1, vecs[i].data, 1'b0};
`endif
            run_frame(vecs[i].data, exp_frame);
        end

        // Back-to-back frames from three consecutive pushes.
        wait_idle(2000);
        in_valid = 1'b1;
        in_data  = 8'h01;
        @(posedge clk);
        #1 in_data = 8'h02;
        @(posedge clk);
        #1 in_data = 8'h03;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10 * NB - 2) @(posedge clk);
        #1 check("b2b_stop1", tx_line, 1);
        @(posedge clk);
        #1 check("b2b_start2", tx_line, 0);
        check("b2b_count2", fifo_count, 1);
        repeat (10 * NB - 1) @(posedge clk);
        #1 check("b2b_stop2", tx_line, 1);
        @(posedge clk);
        #1 check("b2b_start3", tx_line, 0);
        check("b2b_count3", fifo_count, 0);
        wait_idle(2000);

        // Fill to full while a frame is active, then release on the next pop.
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(posedge clk);
        #1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            in_data = 8'(8'h20 + n);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) n++;
        end
        check("fill_accepted", n, 4);
        check("fill_count", fifo_count, 4);
        check("fill_ready", in_ready, 0);
        in_data = 8'(8'h20 + n);
        t = 0;
        while (in_ready !== 1'b1 && t < 300) begin
            @(posedge clk);
            #1 t++;
        end
        check("full_release_ready", in_ready, 1);
        check("full_release_count", fifo_count, 3);
        check("full_release_time", t, 10 * NB - 5);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("refill_count", fifo_count, 4);
        check("refill_ready", in_ready, 0);
        wait_idle(3000);

        // Reset during data bit 3 of 0xFF with two bytes queued.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        #1 in_data = 8'h3C;
        @(posedge clk);
        #1 in_data = 8'hC3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (43) @(posedge clk);
        #2;
        check("pre_rst_count", fifo_count, 2);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", tx_line, 1);
        check("rst_mid_count", fifo_count, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_tx", tx_line, 1);
        check("post_rst_busy", busy, 0);

        // Reset while the line is low must force it high without a clock.
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 check("pre_rst2_tx", tx_line, 0);
        rst = 1'b1;
        #1 check("rst2_async_tx", tx_line, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle(5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
